// File: rtl/ifr_pkg.sv
// Shared types and helpers for the instruction-fetch responder.
package ifr_pkg;

   localparam logic [31:0] NOP_INST = 32'h00000013;

   // Default response entry; the top re-declares this with its own widths.
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        err;
   } ifr_resp_t;

   // Width needed to hold a credit count in 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ifr_resp_fifo.sv
// In-order response FIFO. Flush empties it and overrides a same-cycle push.
module ifr_resp_fifo
   import ifr_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = ifr_resp_t
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  T                         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output T                         head,
   output logic [cnt_w(DEPTH)-1:0]  count,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = cnt_w(DEPTH);

   T                 mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign empty   = (count == '0);
   // Head is forced to zero when empty so outputs read 0 out of reset.
   assign head    = empty ? '0 : mem[rd_ptr];

   // Storage array, written on push; contents need no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers and occupancy; power-of-two depth makes pointer wrap natural.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/inst_fetch_responder.sv
// Instruction-fetch responder: credit-limited accept, fixed-latency memory
// read pipeline, in-order response FIFO and jump flush.
// Optional macro IFR_MISALIGN_CHK_EN: misaligned fetches skip the memory
// read and return a NOP flagged with err_o.
module inst_fetch_responder
   import ifr_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int MEM_LATENCY = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              request_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic              ready_o,
   input  logic              flush_i,
   output logic              mem_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              dataOk_o,
   output logic [DATA_W-1:0] data_o,
   output logic [ADDR_W-1:0] addr_o,
   input  logic              resp_ready_i,
   output logic              err_o
);

   localparam int CNT_W = cnt_w(DEPTH);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              err;
   } resp_t;

   logic                               accepted;
   logic                               misalign;
   logic [MEM_LATENCY:1]               vld_pipe;
   logic [MEM_LATENCY:1][ADDR_W-1:0]   addr_pipe;
   logic [MEM_LATENCY:1]               err_pipe;
   logic [CNT_W-1:0]                   inflight_cnt;
   logic [CNT_W-1:0]                   fifo_cnt;
   logic [CNT_W-1:0]                   outstanding;
   logic                               fifo_empty;
   resp_t                              push_data;
   resp_t                              head;

`ifdef IFR_MISALIGN_CHK_EN
   assign misalign = |addr_i[1:0];
`else
   assign misalign = 1'b0;
`endif

   // ready_o depends on registered state only, so a same-cycle pop does not
   // free a credit until the following cycle.
   assign outstanding = inflight_cnt + fifo_cnt;
   assign ready_o     = (outstanding < CNT_W'(DEPTH));
   assign accepted    = request_i && ready_o;
   assign mem_en_o    = accepted && !misalign;
   assign mem_addr_o  = mem_en_o ? {addr_i[ADDR_W-1:2], 2'b00} : '0;

   // Count valid reads still travelling towards the memory data return.
   always_comb begin
      inflight_cnt = '0;
      for (int i = 1; i <= MEM_LATENCY; i++)
         inflight_cnt = inflight_cnt + CNT_W'(vld_pipe[i]);
   end

   // In-flight shift register; flush kills older stages but keeps the
   // request accepted in the flush cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe  <= '0;
         addr_pipe <= '0;
         err_pipe  <= '0;
      end else begin
         vld_pipe[1]  <= accepted;
         addr_pipe[1] <= addr_i;
         err_pipe[1]  <= misalign;
         for (int i = 2; i <= MEM_LATENCY; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1] && !flush_i;
            addr_pipe[i] <= addr_pipe[i-1];
            err_pipe[i]  <= err_pipe[i-1];
         end
      end
   end

   // Memory data lines up with the last stage; errored entries carry a NOP.
   always_comb begin
      push_data      = '0;
      push_data.addr = addr_pipe[MEM_LATENCY];
      push_data.err  = err_pipe[MEM_LATENCY];
      push_data.data = err_pipe[MEM_LATENCY] ? DATA_W'(NOP_INST) : mem_rdata_i;
   end

   ifr_resp_fifo #(
      .DEPTH (DEPTH),
      .T     (resp_t)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (vld_pipe[MEM_LATENCY]),
      .push_data (push_data),
      .pop       (resp_ready_i),
      .flush     (flush_i),
      .head      (head),
      .count     (fifo_cnt),
      .empty     (fifo_empty)
   );

   assign dataOk_o = !fifo_empty;
   assign data_o   = head.data;
   assign addr_o   = head.addr;
   assign err_o    = head.err;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench for inst_fetch_responder (DEPTH=4, MEM_LATENCY=2).
module tb_inst_fetch_responder;

   localparam int DEPTH = 4;
   localparam int LAT   = 2;
   localparam int AW    = 32;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          request_i = 1'b0;
   logic [AW-1:0] addr_i = '0;
   logic          ready_o;
   logic          flush_i = 1'b0;
   logic          mem_en_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_rdata_i;
   logic          dataOk_o;
   logic [DW-1:0] data_o;
   logic [AW-1:0] addr_o;
   logic          resp_ready_i = 1'b0;
   logic          err_o;

   int checks = 0;
   int errors = 0;

   inst_fetch_responder #(
      .DEPTH(DEPTH), .MEM_LATENCY(LAT), .ADDR_W(AW), .DATA_W(DW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .request_i(request_i), .addr_i(addr_i),
      .ready_o(ready_o), .flush_i(flush_i), .mem_en_o(mem_en_o),
      .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i), .dataOk_o(dataOk_o),
      .data_o(data_o), .addr_o(addr_o), .resp_ready_i(resp_ready_i), .err_o(err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A00_0000);
   endfunction

   // Fixed-latency memory model: data for an enabled read appears LAT cycles later.
   logic [LAT:1]         m_en = '0;
   logic [LAT:1][AW-1:0] m_addr = '0;
   always @(posedge clk) begin
      m_en[1]   <= mem_en_o;
      m_addr[1] <= mem_addr_o;
      for (int i = 2; i <= LAT; i++) begin
         m_en[i]   <= m_en[i-1];
         m_addr[i] <= m_addr[i-1];
      end
   end
   assign mem_rdata_i = m_en[LAT] ? mem_word(m_addr[LAT]) : 32'hBADBAD00;

   // One cycle: drive inputs at the falling edge, settle, then caller checks.
   task automatic cyc(input logic rq, input logic [31:0] a, input logic fl, input logic rr);
      @(negedge clk);
      request_i    = rq;
      addr_i       = a;
      flush_i      = fl;
      resp_ready_i = rr;
      #1;
   endtask

   initial begin
      int issued, received, first_cyc, last_cyc;
      logic [31:0] expq[$];
      logic [31:0] ea;

      // Reset state
      cyc(0, 0, 0, 0);
      chk("rst ready", ready_o, 1);
      chk("rst dataOk", dataOk_o, 0);
      chk("rst data", data_o, 0);
      chk("rst addr", addr_o, 0);
      chk("rst err", err_o, 0);
      chk("rst mem_en", mem_en_o, 0);
      reset_n = 1'b1;

      // Single request, latency MEM_LATENCY+1
      cyc(1, 32'h100, 0, 0);
      chk("t1 mem_en", mem_en_o, 1);
      chk("t1 mem_addr", mem_addr_o, 32'h100);
      cyc(0, 0, 0, 0);
      chk("t1 c1 dataOk", dataOk_o, 0);
      cyc(0, 0, 0, 0);
      chk("t1 c2 dataOk", dataOk_o, 0);
      cyc(0, 0, 0, 1);
      chk("t1 c3 dataOk", dataOk_o, 1);
      chk("t1 data", data_o, 32'hDEADBEEF);
      chk("t1 addr", addr_o, 32'h100);
      cyc(0, 0, 0, 0);
      chk("t1 after pop dataOk", dataOk_o, 0);
      chk("t1 after pop ready", ready_o, 1);

      // Fill all credits with no consumer
      for (int i = 0; i < 4; i++) begin
         cyc(1, 32'(4 * i), 0, 0);
         chk("t2 ready pre", ready_o, 1);
      end
      for (int i = 0; i < 3; i++) begin
         cyc(1, 32'h10, 0, 0);
         chk("t2 ready full", ready_o, 0);
         chk("t2 no mem_en", mem_en_o, 0);
      end
      cyc(0, 0, 0, 1);
      chk("t2 head dataOk", dataOk_o, 1);
      chk("t2 head addr", addr_o, 0);
      cyc(0, 0, 0, 0);
      chk("t2 credit back", ready_o, 1);
      chk("t2 next addr", addr_o, 4);
      for (int k = 1; k < 4; k++) begin
         cyc(0, 0, 0, 1);
         chk("t2 drain addr", addr_o, 32'(4 * k));
         chk("t2 drain data", data_o, mem_word(32'(4 * k)));
      end
      cyc(0, 0, 0, 0);
      chk("t2 empty", dataOk_o, 0);

      // Streaming 16 requests with consumer always ready
      issued = 0; received = 0; first_cyc = -1; last_cyc = -1;
      for (int c = 0; c < 200 && received < 16; c++) begin
         cyc(issued < 16, 32'h400 + 32'(4 * issued), 0, 1);
         if (dataOk_o) begin
            if (expq.size() == 0) begin
               chk("t3 unexpected resp", 1, 0);
            end else begin
               ea = expq.pop_front();
               chk("t3 addr", addr_o, ea);
               chk("t3 data", data_o, mem_word(ea));
            end
            if (first_cyc < 0) first_cyc = c;
            last_cyc = c;
            received++;
         end
         if (request_i && ready_o) begin
            expq.push_back(addr_i);
            issued++;
         end
      end
      chk("t3 count", received, 16);
      chk("t3 back-to-back", last_cyc - first_cyc, 15);

      // Flush with 2 buffered + 2 in flight; no credit for same-cycle request
      for (int i = 0; i < 4; i++) cyc(1, 32'h300 + 32'(4 * i), 0, 0);
      cyc(1, 32'h200, 1, 0);
      chk("t4a ready at flush", ready_o, 0);
      chk("t4a dataOk at flush", dataOk_o, 1);
      for (int k = 0; k < 6; k++) begin
         cyc(0, 0, 0, 1);
         chk("t4a stale dataOk", dataOk_o, 0);
         if (k == 0) chk("t4a ready after", ready_o, 1);
      end

      // Flush with request accepted in the flush cycle
      cyc(1, 32'h500, 0, 0);
      cyc(1, 32'h504, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(1, 32'h508, 0, 0);
      cyc(1, 32'h200, 1, 0);
      chk("t4b ready at flush", ready_o, 1);
      chk("t4b head pre-flush", addr_o, 32'h500);
      chk("t4b mem_en", mem_en_o, 1);
      cyc(0, 0, 0, 0);
      chk("t4b c1 dataOk", dataOk_o, 0);
      cyc(0, 0, 0, 0);
      chk("t4b c2 dataOk", dataOk_o, 0);
      cyc(0, 0, 0, 1);
      chk("t4b c3 dataOk", dataOk_o, 1);
      chk("t4b addr", addr_o, 32'h200);
      chk("t4b data", data_o, mem_word(32'h200));
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 0, 1);
         chk("t4b no stale", dataOk_o, 0);
      end

      // Misaligned fetch
      cyc(1, 32'h102, 0, 0);
`ifdef IFR_MISALIGN_CHK_EN
      chk("t5 mem_en", mem_en_o, 0);
`else
      chk("t5 mem_en", mem_en_o, 1);
      chk("t5 mem_addr", mem_addr_o, 32'h100);
`endif
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1);
      chk("t5 dataOk", dataOk_o, 1);
      chk("t5 addr", addr_o, 32'h102);
`ifdef IFR_MISALIGN_CHK_EN
      chk("t5 data", data_o, 32'h00000013);
      chk("t5 err", err_o, 1);
`else
      chk("t5 data", data_o, 32'hDEADBEEF);
      chk("t5 err", err_o, 0);
`endif

      // Reset with 3 outstanding
      cyc(1, 32'h700, 0, 0);
      cyc(1, 32'h704, 0, 0);
      cyc(1, 32'h708, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("t6 pre-reset dataOk", dataOk_o, 1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("t6 reset dataOk", dataOk_o, 0);
      chk("t6 reset ready", ready_o, 1);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      cyc(1, 32'h710, 0, 0);
      cyc(0, 0, 0, 0);
      chk("t6 c1 dataOk", dataOk_o, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1);
      chk("t6 dataOk", dataOk_o, 1);
      chk("t6 addr", addr_o, 32'h710);
      chk("t6 data", data_o, mem_word(32'h710));
      cyc(0, 0, 0, 0);
      chk("t6 empty", dataOk_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
